pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_unit_adder.sv | 15 +
 rtl/pc_unit.sv | 91 +++++++++
 tb/tb_pc_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, reset/step defaults and PC FSM states.
// Imported by pc_unit and Adder_PC.
package cpu_pkg;

   localparam int unsigned PC_W = 16;

   localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 16'h0000;
   localparam logic [PC_W-1:0] PC_STEP_DEF      = 16'h0002;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_HALT  = 2'b01,
      ST_FAULT = 2'b10
   } pc_state_e;

endpackage

// File: rtl/pc_unit_adder.sv
// Sequential-PC adder: sum = a + STEP, wrapping modulo 2^W.
// Used by pc_unit to form PC_next_seq.
module Adder_PC
   import cpu_pkg::*;
#(
   parameter int unsigned   W    = PC_W,
   parameter logic [W-1:0]  STEP = PC_STEP_DEF
) (
   input  logic [W-1:0] a_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = a_i + STEP;

endmodule

// File: rtl/pc_unit.sv
// Program counter with RUN/HALT/FAULT control FSM and registered PC.
// Optional macro PC_ALIGN_CHECK_EN faults on odd redirect targets.
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [PC_W-1:0] PC_STEP      = PC_STEP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] JB_Add_out,
   input  logic            jump,
   input  logic            branch_taken,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   output logic [PC_W-1:0] PC_out,
   output logic [PC_W-1:0] PC_next_seq,
   output logic [1:0]      state,
   output logic            halted,
   output logic            fault
);

   logic [PC_W-1:0] pc_q;
   pc_state_e       state_q;
   logic            redirect;

   assign redirect = jump | branch_taken;

   Adder_PC #(
      .W    (PC_W),
      .STEP (PC_STEP)
   ) u_adder (
      .a_i   (pc_q),
      .sum_o (PC_next_seq)
   );

   // PC register and control FSM; halt > stall > redirect > sequential
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_VECTOR;
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (halt) begin
                  state_q <= ST_HALT;
               end else if (stall) begin
                  pc_q <= pc_q;
               end else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                  if (JB_Add_out[0]) begin
                     state_q <= ST_FAULT;
                  end else begin
                     pc_q <= JB_Add_out;
                  end
`else
                  pc_q <= JB_Add_out;
`endif
               end else begin
                  pc_q <= PC_next_seq;
               end
            end
            ST_HALT: begin
               if (resume && !halt) begin
                  state_q <= ST_RUN;
               end
            end
`ifdef PC_ALIGN_CHECK_EN
            ST_FAULT: begin
               state_q <= ST_FAULT;
            end
`endif
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   assign PC_out = pc_q;
   assign state  = state_q;
   assign halted = (state_q == ST_HALT);

`ifdef PC_ALIGN_CHECK_EN
   assign fault = (state_q == ST_FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit.
// Build with +define+PC_ALIGN_CHECK_EN to exercise the alignment fault.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] JB_Add_out = '0;
   logic        jump = 1'b0;
   logic        branch_taken = 1'b0;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;
   logic [15:0] PC_out;
   logic [15:0] PC_next_seq;
   logic [1:0]  state;
   logic        halted;
   logic        fault;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk          (clk),
      .rst          (rst),
      .JB_Add_out   (JB_Add_out),
      .jump         (jump),
      .branch_taken (branch_taken),
      .stall        (stall),
      .halt         (halt),
      .resume       (resume),
      .PC_out       (PC_out),
      .PC_next_seq  (PC_next_seq),
      .state        (state),
      .halted       (halted),
      .fault        (fault)
   );

   typedef struct {
      logic        rst;
      logic        jump;
      logic        br;
      logic        stall;
      logic        halt;
      logic        resume;
      logic [15:0] jb;
      logic [15:0] exp_pc;
      logic [15:0] exp_nseq;
      logic [1:0]  exp_st;
   } vec_t;

   localparam logic [1:0] RUN   = 2'b00;
   localparam logic [1:0] HALT  = 2'b01;
   localparam logic [1:0] FAULT = 2'b10;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic r, input logic j, input logic b,
      input logic s, input logic h, input logic rs,
      input logic [15:0] jb, input logic [15:0] pc,
      input logic [15:0] nseq, input logic [1:0] st);
      vec_t v;
      v.rst = r; v.jump = j; v.br = b; v.stall = s;
      v.halt = h; v.resume = rs; v.jb = jb;
      v.exp_pc = pc; v.exp_nseq = nseq; v.exp_st = st;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_row(input int idx, input vec_t v);
      chk("PC_out", idx, PC_out, v.exp_pc);
      chk("PC_next_seq", idx, PC_next_seq, v.exp_nseq);
      chk("state", idx, {14'd0, state}, {14'd0, v.exp_st});
      chk("halted", idx, {15'd0, halted},
          {15'd0, (v.exp_st == HALT)});
      chk("fault", idx, {15'd0, fault},
          {15'd0, (v.exp_st == FAULT)});
   endtask

   initial begin
      //         r  j  b  s  h  rs jb       pc       nseq     st
      tbl.push_back(mk(1,0,0,0,0,0,16'h0000,16'h0000,16'h0002,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0002,16'h0004,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0004,16'h0006,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0006,16'h0008,RUN));
      tbl.push_back(mk(1,0,0,0,0,0,16'h0000,16'h0000,16'h0002,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0002,16'h0004,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0004,16'h0006,RUN));
      tbl.push_back(mk(0,1,0,0,0,0,16'h0040,16'h0040,16'h0042,RUN));
      tbl.push_back(mk(0,0,1,1,0,0,16'h0100,16'h0040,16'h0042,RUN));
      tbl.push_back(mk(0,0,0,1,0,0,16'h0000,16'h0040,16'h0042,RUN));
      tbl.push_back(mk(0,1,1,0,0,0,16'hFFFE,16'hFFFE,16'h0000,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0000,16'h0002,RUN));
      tbl.push_back(mk(0,1,0,0,0,0,16'h0010,16'h0010,16'h0012,RUN));
      tbl.push_back(mk(0,1,0,0,1,0,16'h0080,16'h0010,16'h0012,HALT));
      tbl.push_back(mk(0,1,0,0,0,0,16'h0080,16'h0010,16'h0012,HALT));
      tbl.push_back(mk(0,0,1,1,0,0,16'h0080,16'h0010,16'h0012,HALT));
      tbl.push_back(mk(0,1,0,0,0,0,16'h0080,16'h0010,16'h0012,HALT));
      tbl.push_back(mk(0,0,0,0,1,1,16'h0000,16'h0010,16'h0012,HALT));
      tbl.push_back(mk(0,0,0,0,0,1,16'h0000,16'h0010,16'h0012,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0012,16'h0014,RUN));
      tbl.push_back(mk(0,0,0,0,1,0,16'h0000,16'h0012,16'h0014,HALT));
      tbl.push_back(mk(1,1,0,0,0,0,16'h0080,16'h0000,16'h0002,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0002,16'h0004,RUN));
`ifdef PC_ALIGN_CHECK_EN
      tbl.push_back(mk(0,0,1,0,0,0,16'h0031,16'h0002,16'h0004,FAULT));
      tbl.push_back(mk(0,1,0,0,0,1,16'h0040,16'h0002,16'h0004,FAULT));
`else
      tbl.push_back(mk(0,0,1,0,0,0,16'h0031,16'h0031,16'h0033,RUN));
      tbl.push_back(mk(0,1,0,0,0,1,16'h0040,16'h0040,16'h0042,RUN));
`endif
      tbl.push_back(mk(1,0,0,0,0,0,16'h0000,16'h0000,16'h0002,RUN));
      tbl.push_back(mk(0,0,0,0,0,0,16'h0000,16'h0002,16'h0004,RUN));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst          = tbl[i].rst;
         jump         = tbl[i].jump;
         branch_taken = tbl[i].br;
         stall        = tbl[i].stall;
         halt         = tbl[i].halt;
         resume       = tbl[i].resume;
         JB_Add_out   = tbl[i].jb;
         if (tbl[i].rst) begin
            // asynchronous effect: visible before any clock edge
            #1;
            chk_row(i, tbl[i]);
         end
         @(posedge clk);
         #1;
         chk_row(i, tbl[i]);
      end

      @(negedge clk);
      rst = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
